cache_miss_controller: RTL and testbench

Single-requester controller that sequences port 0 of the set-associative cache array for a core-side load/store interface. It performs tag lookups, serves hits, and handles misses by writing back a dirty victim and refilling the line from next-level memory. It sits between the core memory stage, the cache array and the memory/bus interface. It also keeps hit and miss counters.

---
 rtl/cache_miss_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_controller
//  Description : Single-requester sequencer for port 0 of a set-associative
//                cache array. Serves hits, writes back dirty victims,
//                refills lines from next-level memory and counts hits/misses.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_controller #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int OFFSET_BITS   = 2,
  parameter  int INDEX_BITS    = 8,
  parameter  int ADDRESS_BITS  = 32,
  parameter  int WAY_BITS      = 2,
  parameter  int COUNTER_WIDTH = 32,
  localparam int TAG_BITS      = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS,
  localparam int BLOCK         = DATA_WIDTH << OFFSET_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  // core side
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_BITS-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  // cache array port 0
  output logic                     c_read,
  output logic                     c_write,
  output logic                     c_invalidate,
  output logic [INDEX_BITS-1:0]    c_index,
  output logic [TAG_BITS-1:0]      c_tag,
  output logic [3:0]               c_meta,
  output logic [BLOCK-1:0]         c_data_in,
  output logic [WAY_BITS-1:0]      c_way_select,
  input  logic [BLOCK-1:0]         c_data_out,
  input  logic [TAG_BITS-1:0]      c_tag_out,
  input  logic [WAY_BITS-1:0]      c_matched_way,
  input  logic [1:0]               c_coh,
  input  logic [1:0]               c_status,
  input  logic                     c_hit,
  // next-level memory
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_BITS-1:0]  mem_addr,
  output logic [BLOCK-1:0]         mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [BLOCK-1:0]         mem_rdata,
  // statistics
  output logic [COUNTER_WIDTH-1:0] hit_count,
  output logic [COUNTER_WIDTH-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_REFILL_REQ  = 3'd3,
    S_REFILL_WAIT = 3'd4,
    S_UPDATE      = 3'd5,
    S_RESPOND     = 3'd6
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] c_cnt_max = '1;

  state_t                  r_state;
  state_t                  w_next_state;

  logic                    r_we;
  logic [OFFSET_BITS-1:0]  r_offset;
  logic [INDEX_BITS-1:0]   r_index;
  logic [TAG_BITS-1:0]     r_tag;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [WAY_BITS-1:0]     r_victim_way;
  logic [TAG_BITS-1:0]     r_victim_tag;
  logic [BLOCK-1:0]        r_victim_data;
  logic [BLOCK-1:0]        r_line;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [COUNTER_WIDTH-1:0] r_hit_count;
  logic [COUNTER_WIDTH-1:0] r_miss_count;

  // Replace one word of a line with the store data.
  function automatic logic [BLOCK-1:0] merge_word(input logic [BLOCK-1:0]       line,
                                                  input logic [OFFSET_BITS-1:0] off,
                                                  input logic [DATA_WIDTH-1:0]  word);
    logic [BLOCK-1:0] result;
    result = line;
    result[32'(off) * DATA_WIDTH +: DATA_WIDTH] = word;
    return result;
  endfunction

  // Select one word of a line.
  function automatic logic [DATA_WIDTH-1:0] pick_word(input logic [BLOCK-1:0]       line,
                                                      input logic [OFFSET_BITS-1:0] off);
    return line[32'(off) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign c_invalidate = 1'b0;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

  // State register plus the request, victim and refill datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_offset      <= '0;
      r_index       <= '0;
      r_tag         <= '0;
      r_wdata       <= '0;
      r_victim_way  <= '0;
      r_victim_tag  <= '0;
      r_victim_data <= '0;
      r_line        <= '0;
      r_rdata       <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we     <= cpu_we;
            r_offset <= cpu_addr[OFFSET_BITS-1:0];
            r_index  <= cpu_addr[OFFSET_BITS +: INDEX_BITS];
            r_tag    <= cpu_addr[ADDRESS_BITS-1 -: TAG_BITS];
            r_wdata  <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          if (c_hit) begin
            if (r_hit_count != c_cnt_max) r_hit_count <= r_hit_count + 1'b1;
            r_rdata <= r_we ? '0 : pick_word(c_data_out, r_offset);
          end else begin
            if (r_miss_count != c_cnt_max) r_miss_count <= r_miss_count + 1'b1;
            r_victim_way  <= c_matched_way;
            r_victim_tag  <= c_tag_out;
            r_victim_data <= c_data_out;
          end
        end
        S_REFILL_WAIT: begin
          if (mem_rvalid) begin
            r_line <= r_we ? merge_word(mem_rdata, r_offset, r_wdata) : mem_rdata;
          end
        end
        S_UPDATE: begin
          r_rdata <= r_we ? '0 : pick_word(r_line, r_offset);
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; everything is held quiet while in reset.
  always_comb begin
    w_next_state = r_state;
    cpu_ready    = 1'b0;
    cpu_rvalid   = 1'b0;
    cpu_rdata    = '0;
    c_read       = 1'b0;
    c_write      = 1'b0;
    c_index      = r_index;
    c_tag        = r_tag;
    c_meta       = 4'b0000;
    c_data_in    = '0;
    c_way_select = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          cpu_ready = 1'b1;
          c_index   = cpu_addr[OFFSET_BITS +: INDEX_BITS];
          c_tag     = cpu_addr[ADDRESS_BITS-1 -: TAG_BITS];
          if (cpu_req) begin
            c_read       = 1'b1;
            w_next_state = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (c_hit) begin
            // Write hit updates the array in place, straight from its outputs.
            if (r_we) begin
              c_write      = 1'b1;
              c_way_select = c_matched_way;
              c_data_in    = merge_word(c_data_out, r_offset, r_wdata);
              c_meta       = {2'b11, c_coh};
            end
            w_next_state = S_RESPOND;
          end else if (c_status == 2'b11) begin
            w_next_state = S_WRITEBACK;
          end else begin
            w_next_state = S_REFILL_REQ;
          end
        end
        S_WRITEBACK: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {r_victim_tag, r_index, {OFFSET_BITS{1'b0}}};
          mem_wdata = r_victim_data;
          if (mem_ready) w_next_state = S_REFILL_REQ;
        end
        S_REFILL_REQ: begin
          mem_req  = 1'b1;
          mem_addr = {r_tag, r_index, {OFFSET_BITS{1'b0}}};
          if (mem_ready) w_next_state = S_REFILL_WAIT;
        end
        S_REFILL_WAIT: begin
          if (mem_rvalid) w_next_state = S_UPDATE;
        end
        S_UPDATE: begin
          c_write      = 1'b1;
          c_way_select = r_victim_way;
          c_data_in    = r_line;
          c_meta       = {1'b1, r_we, 2'b00};
          w_next_state = S_RESPOND;
        end
        S_RESPOND: begin
          cpu_rvalid   = 1'b1;
          cpu_rdata    = r_rdata;
          w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_miss_controller
//  Description : Self-checking bench for cache_miss_controller. The bench
//                plays the cache array and the memory, and predicts every
//                transaction from the address-split and line-merge rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_controller;

  logic         clock;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_ready, cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         c_read, c_write, c_invalidate;
  logic [7:0]   c_index;
  logic [21:0]  c_tag;
  logic [3:0]   c_meta;
  logic [127:0] c_data_in;
  logic [1:0]   c_way_select;
  logic [127:0] c_data_out;
  logic [21:0]  c_tag_out;
  logic [1:0]   c_matched_way, c_coh, c_status;
  logic         c_hit;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready, mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count, miss_count;

  int     tests = 0;
  int     fails = 0;
  longint exp_hits = 0;
  longint exp_misses = 0;

  cache_miss_controller dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .c_read(c_read), .c_write(c_write), .c_invalidate(c_invalidate),
    .c_index(c_index), .c_tag(c_tag), .c_meta(c_meta), .c_data_in(c_data_in),
    .c_way_select(c_way_select), .c_data_out(c_data_out), .c_tag_out(c_tag_out),
    .c_matched_way(c_matched_way), .c_coh(c_coh), .c_status(c_status), .c_hit(c_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] line, input int off);
    logic [127:0] t;
    t = line >> (off * 32);
    return t[31:0];
  endfunction

  function automatic logic [127:0] merged(input logic [127:0] line, input int off, input logic [31:0] w);
    logic [127:0] mask, val;
    mask = 128'hFFFF_FFFF << (off * 32);
    val  = {96'd0, w} << (off * 32);
    return (line & ~mask) | val;
  endfunction

  function automatic longint sat_inc(input longint v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete core transaction, called at a step just after a rising edge with the DUT idle.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hit, input logic [1:0] status, input logic [1:0] coh,
                         input logic [1:0] way, input logic [21:0] vtag,
                         input logic [127:0] aline, input logic [127:0] mline,
                         input int swb, input int srf, input int drv);
    int           off;
    logic [7:0]   idx;
    logic [21:0]  tg;
    logic [31:0]  wb_addr, rf_addr, exp_rd;
    logic [127:0] exp_line;
    off     = int'(addr % 4);
    idx     = 8'((addr / 4) % 256);
    tg      = 22'(addr / 1024);
    wb_addr = ({10'd0, vtag} * 1024) + ({24'd0, idx} * 4);
    rf_addr = addr - (addr % 4);

    c_hit = hit; c_status = status; c_coh = coh; c_matched_way = way;
    c_tag_out = vtag; c_data_out = aline;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    check("accept_ready", cpu_ready, 1'b1);
    check("accept_c_read", c_read, 1'b1);
    check("accept_index", c_index, idx);
    check("accept_tag", c_tag, tg);
    tick;
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom);

    if (hit) begin
      exp_hits = sat_inc(exp_hits);
      if (we) begin
        check("whit_c_write", c_write, 1'b1);
        check("whit_way", c_way_select, way);
        check("whit_index", c_index, idx);
        check("whit_data", c_data_in, merged(aline, off, wdata));
        check("whit_meta", c_meta, {2'b11, coh});
        exp_rd = 32'd0;
      end else begin
        check("rhit_no_write", c_write, 1'b0);
        exp_rd = word_of(aline, off);
      end
      tick;
      check("hit_rvalid", cpu_rvalid, 1'b1);
      check("hit_rdata", cpu_rdata, exp_rd);
      check("hit_count", hit_count, exp_hits[31:0]);
      tick;
    end else begin
      exp_misses = sat_inc(exp_misses);
      check("miss_no_write", c_write, 1'b0);
      check("miss_lookup_no_mem", mem_req, 1'b0);
      tick;
      if (status == 2'b11) begin
        for (int i = 0; i <= swb; i++) begin
          check("wb_req", mem_req, 1'b1);
          check("wb_we", mem_we, 1'b1);
          check("wb_addr", mem_addr, wb_addr);
          check("wb_data", mem_wdata, aline);
          mem_ready  = (i == swb);
          mem_rvalid = 1'($urandom);
          mem_rdata  = rand_line();
          tick;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end
      for (int i = 0; i <= srf; i++) begin
        check("rf_req", mem_req, 1'b1);
        check("rf_we", mem_we, 1'b0);
        check("rf_addr", mem_addr, rf_addr);
        mem_ready = (i == srf);
        tick;
      end
      mem_ready = 1'b0;
      for (int i = 0; i <= drv; i++) begin
        check("wait_no_req", mem_req, 1'b0);
        check("wait_no_write", c_write, 1'b0);
        mem_ready  = 1'($urandom);
        mem_rvalid = (i == drv);
        mem_rdata  = mline;
        tick;
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = rand_line();
      exp_line = we ? merged(mline, off, wdata) : mline;
      check("upd_write", c_write, 1'b1);
      check("upd_way", c_way_select, way);
      check("upd_index", c_index, idx);
      check("upd_tag", c_tag, tg);
      check("upd_data", c_data_in, exp_line);
      check("upd_meta", c_meta, {1'b1, we, 2'b00});
      check("miss_count", miss_count, exp_misses[31:0]);
      tick;
      check("miss_rvalid", cpu_rvalid, 1'b1);
      check("miss_rdata", cpu_rdata, we ? 32'd0 : word_of(mline, off));
      tick;
    end
    check("back_idle_ready", cpu_ready, 1'b1);
    check("back_idle_rvalid", cpu_rvalid, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    c_data_out = '0; c_tag_out = '0; c_matched_way = '0; c_coh = '0; c_status = '0; c_hit = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    #1;
    check("rst_rvalid", cpu_rvalid, 1'b0);
    check("rst_c_write", c_write, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_c_read", c_read, 1'b0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    check("rst_invalidate", c_invalidate, 1'b0);
    tick;

    // Read miss, clean victim: index 0x8D, tag 0x4, refill from 0x1234, returns word B.
    run_txn(1'b0, 32'h1235, 32'd0, 1'b0, 2'b00, 2'b00, 2'd1, 22'h3,
            rand_line(), {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, 0, 0, 2);

    // Write hit to word 3 of way 2 with coherence bits 01.
    run_txn(1'b1, 32'h1237, 32'hCAFE_F00D, 1'b1, 2'b10, 2'b01, 2'd2, 22'h0,
            {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000}, '0, 0, 0, 0);

    // Dirty victim with tag 0x1, memory stalls three cycles: writeback to 0x634 then refill.
    run_txn(1'b0, 32'h1235, 32'd0, 1'b0, 2'b11, 2'b10, 2'd3, 22'h1,
            rand_line(), rand_line(), 3, 1, 0);

    // Write miss with dirty victim: store word merged into the refill line.
    run_txn(1'b1, 32'hABCD_0126, 32'h5A5A_1234, 1'b0, 2'b11, 2'b00, 2'd0, 22'h2AAAA,
            rand_line(), rand_line(), 1, 2, 3);

    // Randomised transactions.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
              2'($urandom), 22'($urandom), rand_line(), rand_line(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while waiting for refill data: the late data must be ignored.
    c_hit = 1'b0; c_status = 2'b00; c_matched_way = 2'd1; c_data_out = rand_line();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2468;
    tick;
    cpu_req = 1'b0;
    tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    check("rw_in_wait", mem_req, 1'b0);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    exp_hits = 0; exp_misses = 0;
    #1;
    check("rw_idle_ready", cpu_ready, 1'b1);
    check("rw_mem_req", mem_req, 1'b0);
    check("rw_misses_cleared", miss_count, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rand_line();
    tick;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_write", c_write, 1'b0);
      check("rw_no_rvalid", cpu_rvalid, 1'b0);
      tick;
    end

    // Reset asserted in the array-update cycle: the write strobe drops at once.
    c_hit = 1'b0; c_status = 2'b00;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040;
    tick;
    cpu_req = 1'b0;
    tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    tick;
    mem_rvalid = 1'b0;
    check("ru_write_before", c_write, 1'b1);
    reset = 1'b0;
    #1;
    check("ru_write_gated", c_write, 1'b0);
    tick;
    reset = 1'b1;
    exp_hits = 0; exp_misses = 0;
    #1;
    check("ru_idle_ready", cpu_ready, 1'b1);
    tick;

    // Hit counter saturation.
    force dut.r_hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_count;
    exp_hits = 64'hFFFF_FFFF;
    run_txn(1'b0, 32'h0000_1000, 32'd0, 1'b1, 2'b10, 2'b00, 2'd0, 22'h0,
            rand_line(), '0, 0, 0, 0);
    check("sat_hits", hit_count, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
